// File: rtl/serial_deserializer_if.sv
// serial_deserializer_if: serial bit stream in, parallel word out, status flags.
// master drives sin/sin_valid/sof/msb_first/pready/clr_err; slave is the receiver.
interface serial_deserializer_if #(
  parameter int WIDTH = 4
);
  logic             sin;
  logic             sin_valid;
  logic             sof;
  logic             msb_first;
  logic [WIDTH-1:0] pdata;
  logic             pvalid;
  logic             pready;
  logic             busy;
  logic             overrun;
  logic             frame_err;
  logic             clr_err;

  modport master (
    output sin, sin_valid, sof, msb_first,
    output pready, clr_err,
    input  pdata, pvalid, busy,
    input  overrun, frame_err
  );

  modport slave (
    input  sin, sin_valid, sof, msb_first,
    input  pready, clr_err,
    output pdata, pvalid, busy,
    output overrun, frame_err
  );
endinterface

// File: rtl/serial_deserializer.sv
// serial_deserializer: assembles WIDTH-bit words MSB- or LSB-first per frame.
// Ports: clk, rst (sync, active-high), bus (slave: serial in, pdata/pvalid/pready, flags).
module serial_deserializer #(
  parameter int WIDTH = 4
) (
  input logic clk,
  input logic rst,
  serial_deserializer_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] shifted;
  logic [CW-1:0]    count;
  logic             dir;
  logic             last;

  logic             start;
  logic             shift;
  logic             done;
  logic             ferr_set;

  logic [WIDTH-1:0] pdata_q;
  logic             pvalid_q;
  logic             overrun_q;
  logic             ferr_q;

  assign last    = (count == CW'(WIDTH - 1));
  assign shifted = dir ? {sreg[WIDTH-2:0], bus.sin}
                       : {bus.sin, sreg[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:
        if (bus.sin_valid && bus.sof) state_n = SHIFT;
      SHIFT:
        if (bus.sin_valid && !bus.sof && last) state_n = IDLE;
    endcase
  end

  // sof restarts the frame in either state; in SHIFT it is also a framing error.
  always_comb begin
    start    = bus.sin_valid && bus.sof;
    shift    = 1'b0;
    done     = 1'b0;
    ferr_set = 1'b0;
    if (state == SHIFT) begin
      shift    = bus.sin_valid && !bus.sof;
      done     = shift && last;
      ferr_set = start;
    end
  end

  // The first bit goes onto a cleared register so a restart leaves no stale bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg  <= '0;
      count <= '0;
      dir   <= 1'b0;
    end else if (start) begin
      dir   <= bus.msb_first;
      sreg  <= bus.msb_first ? {{(WIDTH-1){1'b0}}, bus.sin}
                             : {bus.sin, {(WIDTH-1){1'b0}}};
      count <= CW'(1);
    end else if (shift) begin
      sreg  <= shifted;
      count <= last ? '0 : count + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pdata_q   <= '0;
      pvalid_q  <= 1'b0;
      overrun_q <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      unique case (1'b1)
        done && (!pvalid_q || bus.pready): begin
          pdata_q  <= shifted;
          pvalid_q <= 1'b1;
        end
        pvalid_q && bus.pready && !done:
          pvalid_q <= 1'b0;
        default: ;
      endcase
      // Set beats clear when both land in the same cycle.
      overrun_q <= (done && pvalid_q && !bus.pready)
                 || (overrun_q && !bus.clr_err);
      ferr_q    <= ferr_set || (ferr_q && !bus.clr_err);
    end
  end

  assign bus.pdata     = pdata_q;
  assign bus.pvalid    = pvalid_q;
  assign bus.busy      = (state == SHIFT);
  assign bus.overrun   = overrun_q;
  assign bus.frame_err = ferr_q;
endmodule

// File: tb/tb_serial_deserializer.sv
// tb_serial_deserializer: directed frames with hand-computed words and flags.
// Drives the interface master side; checks outputs #1 after each rising edge.
module tb_serial_deserializer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  serial_deserializer_if #(.WIDTH(4)) bus ();

  serial_deserializer #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic b, input logic s, input logic m);
    bus.sin       = b;
    bus.sof       = s;
    bus.msb_first = m;
    bus.sin_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.sin_valid = 1'b0;
    bus.sof       = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [3:0] w, input logic m);
    for (int i = 0; i < 4; i++)
      send(m ? w[3-i] : w[i], i == 0, m);
  endtask

  initial begin
    bus.sin = 0; bus.sin_valid = 0; bus.sof = 0;
    bus.msb_first = 0; bus.pready = 1; bus.clr_err = 0;
    idle(1);
    chk("rst_pdata", 32'(bus.pdata), 0);
    chk("rst_pvalid", 32'(bus.pvalid), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_ovr", 32'(bus.overrun), 0);
    chk("rst_ferr", 32'(bus.frame_err), 0);
    rst = 0;

    send(1, 1, 1); chk("msb_busy1", 32'(bus.busy), 1);
    send(0, 0, 1); chk("msb_busy2", 32'(bus.busy), 1);
    send(1, 0, 1); chk("msb_busy3", 32'(bus.busy), 1);
    send(1, 0, 1); chk("msb_busy4", 32'(bus.busy), 0);
    chk("msb_pdata", 32'(bus.pdata), 32'hB);
    chk("msb_pvalid", 32'(bus.pvalid), 1);
    idle(1);
    chk("msb_pvalid_drop", 32'(bus.pvalid), 0);

    send(1, 1, 0); idle(2);
    chk("lsb_gap_busy", 32'(bus.busy), 1);
    send(0, 0, 1); idle(2);
    send(1, 0, 1); idle(2);
    send(1, 0, 1);
    chk("lsb_pdata", 32'(bus.pdata), 32'hD);
    chk("lsb_pvalid", 32'(bus.pvalid), 1);
    chk("lsb_ovr", 32'(bus.overrun), 0);
    chk("lsb_ferr", 32'(bus.frame_err), 0);
    idle(1);

    bus.pready = 0;
    frame(4'b0011, 1);
    chk("ovr_a_pdata", 32'(bus.pdata), 32'h3);
    chk("ovr_a_flag", 32'(bus.overrun), 0);
    frame(4'b1100, 1);
    chk("ovr_b_pdata", 32'(bus.pdata), 32'h3);
    chk("ovr_b_flag", 32'(bus.overrun), 1);
    chk("ovr_b_pvalid", 32'(bus.pvalid), 1);
    bus.pready = 1; idle(1);
    chk("ovr_drain", 32'(bus.pvalid), 0);
    chk("ovr_sticky", 32'(bus.overrun), 1);
    bus.clr_err = 1; idle(1); bus.clr_err = 0;
    chk("ovr_clr", 32'(bus.overrun), 0);

    bus.pready = 0;
    frame(4'b0011, 1);
    send(1, 1, 1); send(1, 0, 1); send(0, 0, 1);
    bus.pready = 1;
    send(0, 0, 1);
    bus.pready = 0;
    chk("hs_pdata", 32'(bus.pdata), 32'hC);
    chk("hs_pvalid", 32'(bus.pvalid), 1);
    chk("hs_ovr", 32'(bus.overrun), 0);
    bus.pready = 1; idle(1);
    chk("hs_drain", 32'(bus.pvalid), 0);

    send(1, 0, 1);
    chk("stray_busy", 32'(bus.busy), 0);
    chk("stray_ferr", 32'(bus.frame_err), 0);
    send(1, 1, 1); send(0, 0, 1);
    send(0, 1, 1);
    chk("ferr_set", 32'(bus.frame_err), 1);
    chk("ferr_busy", 32'(bus.busy), 1);
    send(1, 0, 1); send(1, 0, 1); send(0, 0, 1);
    chk("ferr_pdata", 32'(bus.pdata), 32'h6);
    chk("ferr_pvalid", 32'(bus.pvalid), 1);
    bus.clr_err = 1; idle(1); bus.clr_err = 0;
    chk("ferr_clr", 32'(bus.frame_err), 0);

    bus.pready = 0;
    frame(4'b1010, 1);
    chk("rm_pre_pdata", 32'(bus.pdata), 32'hA);
    send(1, 1, 1); send(0, 0, 1);
    rst = 1; idle(1); rst = 0;
    chk("rm_pdata", 32'(bus.pdata), 0);
    chk("rm_pvalid", 32'(bus.pvalid), 0);
    chk("rm_busy", 32'(bus.busy), 0);
    chk("rm_ovr", 32'(bus.overrun), 0);
    chk("rm_ferr", 32'(bus.frame_err), 0);
    bus.pready = 1;
    frame(4'b1001, 0);
    chk("rm_post_pdata", 32'(bus.pdata), 32'h9);
    chk("rm_post_pvalid", 32'(bus.pvalid), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
